// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// access-size encodings and byte-lane identifiers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian byte-lane steering: extracts/extends load data from a
// 16-bit word and merges a store byte into a captured word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic        lane_i,
  input  logic        size_i,
  input  logic        signed_i,
  input  logic [7:0]  store_byte_i,
  output logic [15:0] load_data_o,
  output logic [15:0] merged_o
);

  logic [7:0] lane_byte;

  assign lane_byte = (lane_i == LANE_HI) ? word_i[15:8] : word_i[7:0];

  always_comb begin
    load_data_o = word_i;
    if (size_i == SIZE_BYTE) begin
      load_data_o = {(signed_i && lane_byte[7]) ? 8'hFF : 8'h00, lane_byte};
    end
  end

  assign merged_o = (lane_i == LANE_HI) ? {store_byte_i, word_i[7:0]}
                                        : {word_i[15:8], store_byte_i};

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store at a time, byte stores
// done as read-modify-write, misaligned halfwords answered with an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_acess_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic              size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mux_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  // Extraction works on live read data; merging works on the captured word.
  assign mux_word = (state_q == ST_WRITE) ? word_q : mem_read_data;

  lsu_lane_mux u_lane_mux (
    .word_i       (mux_word),
    .lane_i       (addr_q[0]),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .store_byte_i (wdata_q[7:0]),
    .load_data_o  (load_data),
    .merged_o     (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    size_d         = size_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    word_d         = word_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write_en   = 1'b0;
    mem_acess_addr = '0;
    mem_write_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (req_size == SIZE_HALF && req_addr[0]) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        mem_acess_addr = addr_q;
        if (!we_q) begin
          mem_read = rst_n;
          rdata_d  = load_data;
          state_d  = ST_RESP;
        end else if (size_q == SIZE_HALF) begin
          mem_write_en   = rst_n;
          mem_write_data = wdata_q;
          state_d        = ST_RESP;
        end else begin
          mem_read = rst_n;
          word_d   = mem_read_data;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_acess_addr = addr_q;
        mem_write_en   = rst_n;
        mem_write_data = merged_word;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory behind the port, a transaction-level
// reference memory, directed test-plan steps followed by random requests.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_size, req_signed;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata;
  logic [15:0] mem_acess_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  logic [15:0] mem     [0:255] = '{default: 16'h0000};
  logic [15:0] ref_mem [0:255];

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [15:0] wr_addr = 16'h0;
  logic [15:0] rd_addr = 16'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_acess_addr (mem_acess_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Memory aliases every address bit above [8].
  assign mem_read_data = mem_read ? mem[mem_acess_addr[8:1]] : 16'h0000;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_acess_addr[8:1]] <= mem_write_data;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_acess_addr;
    end
    if (mem_read) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= mem_acess_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request from IDLE back to IDLE; called and returning at a negedge.
  task automatic do_req(input logic we, input logic sz, input logic sg,
                        input logic [15:0] a, input logic [15:0] wd, input int hold);
    int          idx, lat, exp_lat, wr0, rd0, exp_w, exp_r;
    logic [15:0] w, b, exp_rd, held;
    logic        exp_err;

    idx     = int'(a[8:1]);
    w       = ref_mem[idx];
    exp_err = sz && a[0];
    exp_rd  = 16'h0000;
    if (exp_err)          exp_lat = 1;
    else if (we && !sz)   exp_lat = 3;
    else                  exp_lat = 2;
    if (!exp_err && !we) begin
      if (sz) exp_rd = w;
      else begin
        b = a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        if (sg && b[7]) b = b + 16'hFF00;
        exp_rd = b;
      end
    end
    exp_w = (!exp_err && we) ? 1 : 0;
    exp_r = (!exp_err && (!we || !sz)) ? 1 : 0;

    check("req_ready_idle", {31'b0, req_ready}, 1);
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_size   = 1'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 8);
    check("latency", lat, exp_lat);
    check("resp_rdata", {16'b0, resp_rdata}, {16'b0, exp_rd});
    check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    held = resp_rdata;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, resp_valid}, 1);
      check("hold_rdata", {16'b0, resp_rdata}, {16'b0, held});
      check("hold_req_ready", {31'b0, req_ready}, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("ready_after_resp", {31'b0, req_ready}, 1);
    check("valid_after_resp", {31'b0, resp_valid}, 0);
    check("idle_addr", {16'b0, mem_acess_addr}, 0);

    if (exp_w == 1) begin
      if (sz) ref_mem[idx] = wd;
      else    ref_mem[idx] = a[0] ? {wd[7:0], w[7:0]} : {w[15:8], wd[7:0]};
    end
    check("write_strobes", wr_cnt - wr0, exp_w);
    check("read_strobes", rd_cnt - rd0, exp_r);
    if (exp_w == 1) check("write_addr", {16'b0, wr_addr}, {16'b0, a});
    if (exp_r == 1) check("read_addr", {16'b0, rd_addr}, {16'b0, a});
    check("mem_word", {16'b0, mem[idx]}, {16'b0, ref_mem[idx]});
    $display("txn we=%0d size=%0d signed=%0d addr=%h wdata=%h hold=%0d -> rdata=%h err=%0d lat=%0d",
             we, sz, sg, a, wd, hold, exp_rd, exp_err, lat);
  endtask

  initial begin
    int wr0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 16'h0;
    req_wdata  = 16'h0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_rdata", {16'b0, resp_rdata}, 0);
    check("rst_resp_err", {31'b0, resp_err}, 0);
    check("rst_mem_read", {31'b0, mem_read}, 0);
    check("rst_mem_write_en", {31'b0, mem_write_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0);

    do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 0);
    do_req(1'b1, 1'b0, 1'b0, 16'h0021, 16'h55AB, 0);
    check("rmw_hi_word", {16'b0, mem[8'h10]}, 32'h0000AB34);
    do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h99CD, 0);
    check("rmw_lo_word", {16'b0, mem[8'h10]}, 32'h0000ABCD);
    do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 0);

    do_req(1'b1, 1'b1, 1'b0, 16'h0030, 16'h80FF, 0);
    do_req(1'b0, 1'b0, 1'b1, 16'h0031, 16'h0000, 0);
    do_req(1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 0);
    do_req(1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 0);

    do_req(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0000, 0);
    do_req(1'b1, 1'b1, 1'b0, 16'h0041, 16'hDEAD, 0);

    do_req(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 5);

    // Reset landing in the WRITE cycle of a byte store.
    do_req(1'b1, 1'b1, 1'b0, 16'h0050, 16'h5A5A, 0);
    wr0        = wr_cnt;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 1'b0;
    req_signed = 1'b0;
    req_addr   = 16'h0050;
    req_wdata  = 16'h0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw_write_cycle", {31'b0, mem_write_en}, 1);
    rst_n = 1'b0;
    #1;
    check("rmw_gated_write", {31'b0, mem_write_en}, 0);
    @(negedge clk);
    check("rmw_rst_valid", {31'b0, resp_valid}, 0);
    check("rmw_rst_rdata", {16'b0, resp_rdata}, 0);
    check("rmw_rst_err", {31'b0, resp_err}, 0);
    check("rmw_rst_mem_read", {31'b0, mem_read}, 0);
    check("rmw_rst_addr", {16'b0, mem_acess_addr}, 0);
    check("rmw_rst_wdata", {16'b0, mem_write_data}, 0);
    check("rmw_mem_unchanged", {16'b0, mem[8'h28]}, 32'h00005A5A);
    check("rmw_no_write", wr_cnt - wr0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_req_ready", {31'b0, req_ready}, 1);
    $display("txn reset during byte-store WRITE at addr=0050");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra;
      ra = 16'($urandom);
      if (n % 2 == 0) ra[15:9] = 7'h00;
      do_req(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the processor's data-memory interface: accepts load/store requests from the execute stage over a valid/ready handshake and drives the `data_memory` port (`mem_acess_addr`, `mem_write_data`, `mem_write_en`, `mem_read`, `mem_read_data`).
- Supports byte and halfword accesses on the 16-bit-word memory.
- Byte stores are done as read-modify-write.
- Load data is extracted and extended.
- Each request returns exactly one response, with a misalignment error flag.

## Interface
- `DATA_W`, 16: memory word and request data width; fixed at 16 for byte-lane logic.
- `ADDR_W`, 16: byte address width.
- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 1: 0 = byte, 1 = halfword.
- `req_signed` in 1: sign-extend byte loads; ignored otherwise.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data; byte stores use `[7:0]`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out DATA_W: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned halfword access.
- `mem_acess_addr` out 16: address to `data_memory`.
- `mem_write_data` out 16: write word.
- `mem_write_en` out 1: write strobe, sampled by memory at `clk` edge.
- `mem_read` out 1: read enable.
- `mem_read_data` in 16: combinational read data; 0 when `mem_read` = 0.

## Operation
- **States:** IDLE, ACCESS, WRITE, RESP.
- **Request latch:** the request is latched on `req_valid && req_ready`.
  - `req_ready` = 1 only in IDLE.
- **Misaligned halfword** (`req_size`=1, `req_addr[0]`=1):
  - IDLE → RESP directly, with `resp_err`=1 and `resp_rdata`=0.
  - No memory strobe at any time.
- **Otherwise IDLE → ACCESS.**
- **ACCESS, load:**
  - `mem_read`=1; `mem_acess_addr` = latched address.
  - `mem_read_data` is captured at the ending edge; → RESP.
- **ACCESS, halfword store:**
  - `mem_write_en`=1; `mem_write_data` = latched wdata; → RESP.
- **ACCESS, byte store:** `mem_read`=1; the full word is captured; → WRITE.
- **WRITE:**
  - `mem_write_en`=1, with the merged word.
  - Lane `addr[0]`=0 replaces `[7:0]`; lane 1 replaces `[15:8]`.
  - The other byte is preserved from the captured word. → RESP.
- **Byte-lane order:** little-endian. Byte at `addr[0]`=0 is `[7:0]`; `addr[0]`=1 is `[15:8]`.
- **Load extraction:**
  - Halfword: word as-is.
  - Byte: selected lane in `[7:0]`; upper bits are zero, or replicate bit 7 when `req_signed`=1.
- **RESP:**
  - `resp_valid`=1; `resp_rdata`/`resp_err` held stable.
  - Leave to IDLE on `resp_ready`=1. Stay while `resp_ready`=0.
- **Memory outputs outside ACCESS/WRITE:** `mem_read`=0, `mem_write_en`=0, `mem_acess_addr`=0, `mem_write_data`=0.
- **Address bits above [8]:** passed through unchecked; the memory aliases them.
- **Single outstanding request:** no pipelining; a new request is accepted only in IDLE.

## Timing
- **Reset (`rst_n`=0 at an edge):**
  - State → IDLE.
  - All registered outputs (`resp_valid`, `resp_rdata`, `resp_err`, captured word, latched request) → 0.
  - `req_ready`=1 after the reset edge.
- **Reset gating:** `mem_write_en` and `mem_read` are gated by `rst_n`. No write occurs in any cycle with `rst_n`=0, even in WRITE; an in-flight RMW is abandoned.
- **Latency:** counted from the accept edge (edge 0).
  - Load / halfword store: ACCESS in cycle 1; `resp_valid` from cycle 2.
  - Byte store: ACCESS cycle 1, WRITE cycle 2, `resp_valid` cycle 3.
  - Misaligned: `resp_valid` cycle 1.
- **Throughput:** back-to-back with `resp_ready` held 1 is one request per 3 cycles (4 for byte stores).
  - RESP → IDLE costs one cycle; no accept in RESP.
- **Input stability:** `req_*` inputs are sampled only at the accept edge; later changes are ignored.
- **Reset with `resp_valid`:** reset while `resp_valid`=1 drops it without handshake.

## Structure
- **Package `lsu_pkg`:**
  - State enum (IDLE, ACCESS, WRITE, RESP).
  - Constants `SIZE_BYTE`=1'b0, `SIZE_HALF`=1'b1.
  - Lane constants `LANE_LO`=0, `LANE_HI`=1.
- **Sub-module `lsu_lane_mux`** (combinational):
  - Inputs: word, lane, size, signed, store byte.
  - Outputs: extracted load value and merged store word.
- **Top level:** the top holds the FSM, request/response registers and memory-port drive.

## Test plan
- **Halfword store then load:** store 0xBEEF @0x0010; load half @0x0010.
  - `mem_write_en` for exactly 1 cycle, with `mem_acess_addr`=0x0010.
  - `resp_rdata`=0xBEEF at cycle 2.
- **Byte RMW:** memory @0x0020 = 0x1234; store byte 0xAB @0x0021.
  - Written word = 0xAB34; response at cycle 3.
  - A byte store 0xCD @0x0020 then gives 0xABCD.
- **Signed/unsigned byte load:** word 0x80FF @0x0030.
  - Byte @0x0031 signed → 0xFF80; unsigned → 0x0080.
  - Byte @0x0030 signed → 0xFFFF.
- **Misaligned halfword:** load half @0x0041.
  - `resp_err`=1 and `resp_rdata`=0 at cycle 1.
  - No `mem_read`/`mem_write_en` pulse; memory unchanged.
- **Response backpressure:** hold `resp_ready`=0 for 5 cycles.
  - `resp_valid`, `resp_rdata` stable; `req_ready`=0 throughout.
  - `req_ready`=1 the cycle after `resp_ready`=1.
- **Reset mid-RMW:** assert `rst_n`=0 in the WRITE cycle of a byte store to 0x0050.
  - Memory word unchanged; all outputs 0; `req_ready`=1 after release.
